// File: rtl/mdriver_arb_pkg.sv
// Shared types for the exec/fin arbiter: FSM states, latched command, read-error pattern.
// Command widths here set the default widths of mdriver_arb.
package mdriver_pkg;

  localparam int CMD_DW = 32;
  localparam int CMD_AW = 9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE,
    RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [CMD_AW-1:0] address;
    logic [CMD_DW-1:0] data;
  } cmd_t;

  // Returned as read data when the downstream slave never answers.
  function automatic logic [CMD_DW-1:0] RDATA_ERR();
    return '1;
  endfunction

endpackage

// File: rtl/mdriver_arb_if.sv
// Upstream N-channel and downstream single-port exec/fin bundle.
// slave = the arbiter's view; master = the requesters/downstream-responder view.
interface mdriver_arb_if
  import mdriver_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = CMD_DW,
  parameter int ADDR_W = CMD_AW
);

  logic [N_CH-1:0]             up_exec;
  logic [N_CH-1:0]             up_we;
  logic [N_CH-1:0][ADDR_W-1:0] up_address;
  logic [N_CH-1:0][DATA_W-1:0] up_data;
  logic [N_CH-1:0][DATA_W-1:0] up_rdata;
  logic [N_CH-1:0]             up_fin;
  logic [N_CH-1:0]             up_err;

  logic                        dn_exec;
  logic                        dn_we;
  logic [ADDR_W-1:0]           dn_address;
  logic [DATA_W-1:0]           dn_data;
  logic [DATA_W-1:0]           dn_rdata;
  logic                        dn_fin;

  modport slave (
    input  up_exec, up_we, up_address, up_data, dn_rdata, dn_fin,
    output up_rdata, up_fin, up_err, dn_exec, dn_we, dn_address, dn_data
  );

  modport master (
    output up_exec, up_we, up_address, up_data, dn_rdata, dn_fin,
    input  up_rdata, up_fin, up_err, dn_exec, dn_we, dn_address, dn_data
  );

endinterface

// File: rtl/mdriver_arb_rr_arbiter.sv
// Round-robin pick: lowest requesting index at or after last+1 (mod N_CH).
// Purely combinational, zero latency; no grant when no request.
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [N_CH-1:0] gnt_oh_o,
  output logic [IW-1:0]   gnt_idx_o
);

  logic [IW-1:0] c;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    c         = '0;
    for (int k = N_CH; k >= 1; k--) begin
      c = IW'((int'(last_i) + k) % N_CH);
      if (req_i[c]) begin
        gnt_idx_o   = c;
        gnt_oh_o    = '0;
        gnt_oh_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdriver_arb.sv
// N-channel round-robin arbiter replaying 4-phase exec/fin commands onto one slave port.
// Registered outputs, one cycle exec->dn_exec; losers stay pending; optional fin timeout.
module mdriver_arb
  import mdriver_pkg::*;
#(
  parameter int N_CH             = 4,
  parameter int C_AXI_DATA_WIDTH = CMD_DW,
  parameter int C_AXI_ADDR_WIDTH = CMD_AW,
  parameter int TIMEOUT          = 256
) (
  input logic          clk,
  input logic          nreset,
  mdriver_arb_if.slave bus
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(N_CH - 1);

  state_t                                 state_q, state_d;
  logic [IW-1:0]                          last_q, last_d;
  logic [IW-1:0]                          gnt_q, gnt_d;
  cmd_t                                   cmd_q, cmd_d;
  logic [CW-1:0]                          cnt_q, cnt_d;
  logic                                   dn_exec_q, dn_exec_d;
  logic [N_CH-1:0]                        up_fin_q, up_fin_d;
  logic [N_CH-1:0]                        up_err_q, up_err_d;
  logic [N_CH-1:0][C_AXI_DATA_WIDTH-1:0]  up_rdata_q, up_rdata_d;

  logic [N_CH-1:0] arb_oh;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;

  rr_arbiter #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_rr (
    .req_i     (bus.up_exec),
    .last_i    (last_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx)
  );

  assign arb_vld = |arb_oh;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    dn_exec_d  = dn_exec_q;
    up_fin_d   = up_fin_q;
    up_err_d   = up_err_q;
    up_rdata_d = up_rdata_q;

    unique case (state_q)
      // A lingering dn_fin (late answer to a timed-out command) must drain before issuing.
      IDLE: begin
        if (arb_vld && !bus.dn_fin) begin
          gnt_d         = arb_idx;
          last_d        = arb_idx;
          cmd_d.we      = bus.up_we[arb_idx];
          cmd_d.address = bus.up_address[arb_idx];
          cmd_d.data    = bus.up_data[arb_idx];
          dn_exec_d     = 1'b1;
          state_d       = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.dn_fin) begin
          if (!cmd_q.we) begin
            up_rdata_d[gnt_q] = bus.dn_rdata;
          end
          dn_exec_d = 1'b0;
          state_d   = RELEASE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          dn_exec_d       = 1'b0;
          up_err_d[gnt_q] = 1'b1;
          up_fin_d[gnt_q] = 1'b1;
          if (!cmd_q.we) begin
            up_rdata_d[gnt_q] = RDATA_ERR();
          end
          state_d = RESP;
        end
      end

      RELEASE: begin
        if (!bus.dn_fin) begin
          up_fin_d[gnt_q] = 1'b1;
          state_d         = RESP;
        end
      end

      RESP: begin
        if (!bus.up_exec[gnt_q]) begin
          up_fin_d[gnt_q] = 1'b0;
          up_err_d[gnt_q] = 1'b0;
          cnt_d           = '0;
          state_d         = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      last_q     <= LAST_RST;
      gnt_q      <= '0;
      cmd_q      <= '0;
      cnt_q      <= '0;
      dn_exec_q  <= 1'b0;
      up_fin_q   <= '0;
      up_err_q   <= '0;
      up_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      dn_exec_q  <= dn_exec_d;
      up_fin_q   <= up_fin_d;
      up_err_q   <= up_err_d;
      up_rdata_q <= up_rdata_d;
    end
  end

  assign bus.dn_exec    = dn_exec_q;
  assign bus.dn_we      = cmd_q.we;
  assign bus.dn_address = cmd_q.address;
  assign bus.dn_data    = cmd_q.data;
  assign bus.up_fin     = up_fin_q;
  assign bus.up_err     = up_err_q;
  assign bus.up_rdata   = up_rdata_q;

endmodule
